// File: rtl/demux1to8_sipo.sv
// Serial-to-parallel demux: bit accepted at select k lands in word[k]; full word is presented with a 1-cycle strobe.
// Latency 1 clk from last bit to dout_valid; no backpressure, gaps in din_valid simply stall the select counter.
module demux1to8_sipo #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             start,
   output logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy
);

   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WIDTH - 1);

   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;

   always_comb begin
      sel_d        = sel_q;
      word_d       = word_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (start) begin
         // Realign: a valid bit on the same edge opens the new frame at bit 0.
         sel_d  = '0;
         word_d = '0;
         if (din_valid) begin
            word_d[0] = din;
            sel_d     = SEL_W'(1);
         end
      end else if (din_valid) begin
         word_d[sel_q] = din;
         if (sel_q == SEL_MAX) begin
            dout_d       = word_d;
            dout_valid_d = 1'b1;
            word_d       = '0;
            sel_d        = '0;
         end else begin
            sel_d = sel_q + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q        <= '0;
         word_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         word_q       <= word_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign sel        = sel_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (sel_q != '0);

endmodule
